// File: rtl/crc_pkg.sv
// Shared CRC helpers: bit-reflection functions, checker FSM states and a
// catalogue of common CRC presets.
package crc_pkg;

    typedef enum logic [1:0] {
        ACC    = 2'd0,
        CALC   = 2'd1,
        RESULT = 2'd2
    } fsm_state_t;

    // CRC-8 (poly 0x07)
    localparam int          CRC8_BITS    = 8;
    localparam logic [31:0] CRC8_POLY    = 32'h0000_0007;
    localparam logic [31:0] CRC8_INIT    = 32'h0000_0000;
    localparam bit          CRC8_REFIN   = 1'b0;
    localparam bit          CRC8_REFOUT  = 1'b0;
    localparam logic [31:0] CRC8_XOROUT  = 32'h0000_0000;

    // CRC-16/CCITT-FALSE
    localparam int          CRC16_BITS   = 16;
    localparam logic [31:0] CRC16_POLY   = 32'h0000_1021;
    localparam logic [31:0] CRC16_INIT   = 32'h0000_FFFF;
    localparam bit          CRC16_REFIN  = 1'b0;
    localparam bit          CRC16_REFOUT = 1'b0;
    localparam logic [31:0] CRC16_XOROUT = 32'h0000_0000;

    // CRC-32 (Ethernet / zip)
    localparam int          CRC32_BITS   = 32;
    localparam logic [31:0] CRC32_POLY   = 32'h04C1_1DB7;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam bit          CRC32_REFIN  = 1'b1;
    localparam bit          CRC32_REFOUT = 1'b1;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFF_FFFF;

    // Mirror the bit order of a byte.
    function automatic logic [7:0] reflect8(input logic [7:0] b);
        return {b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]};
    endfunction

    // Mirror the low w bits of v (w <= 32); upper result bits are zero.
    function automatic logic [31:0] reflect_bits(input logic [31:0] v, input int w);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        t = v;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r = {r[30:0], t[0]};
                t = t >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/crc_process_byte.sv
// Combinational byte step of a normal-form (MSB-first) CRC register:
// the byte is XORed into the top of the register, then eight shift/divide steps.
module crc_process_byte #(
    parameter int              bits = 8,
    parameter logic [bits-1:0] poly = bits'(8'h33)
) (
    input  logic            refin_in,
    input  logic [bits-1:0] crc_in,
    input  logic [7:0]      byte_in,
    output logic [bits-1:0] crc_out
);
    import crc_pkg::*;

    logic [7:0]      byte_ordered;
    logic [bits-1:0] stage [0:8];

    assign byte_ordered = refin_in ? reflect8(byte_in) : byte_in;
    assign stage[0]     = crc_in ^ (bits'(byte_ordered) << (bits - 8));

    // One polynomial division step per message bit.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bit
            assign stage[gi+1] = stage[gi][bits-1] ? ((stage[gi] << 1) ^ poly)
                                                   : (stage[gi] << 1);
        end
    endgenerate

    assign crc_out = stage[8];

endmodule

// File: rtl/crc_frame_checker.sv
// Receive-side CRC verifier. The trailing bits/8 bytes of each frame are held
// back in a delay line so that only payload bytes reach the CRC register; at
// frame end the held bytes are the received CRC and are compared against the
// finalised computed CRC.
module crc_frame_checker #(
    parameter int              bits          = 8,
    parameter logic [bits-1:0] poly          = bits'(8'h33),
    parameter logic [bits-1:0] init          = '0,
    parameter bit              refin         = 1'b0,
    parameter bit              refout        = 1'b0,
    parameter logic [bits-1:0] xorout        = '0,
    parameter bit              crc_msb_first = 1'b1,
    parameter int              len_w         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_ok,
    output logic             res_short,
    output logic [bits-1:0]  res_crc,
    output logic [len_w-1:0] res_len
);
    import crc_pkg::*;

    localparam int                N         = bits / 8;
    localparam int                FILL_W    = $clog2(N + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);

    fsm_state_t        state_reg;
    fsm_state_t        state_next;
    logic              in_ready_reg;
    logic [7:0]        dl_reg [N];
    logic [FILL_W-1:0] fill_reg;
    logic [len_w-1:0]  len_reg;
    logic [bits-1:0]   crc_reg;
    logic [bits-1:0]   crc_step;
    logic [bits-1:0]   crc_refl;
    logic [bits-1:0]   crc_fin;
    logic [bits-1:0]   rx_crc;
    logic              beat;
    logic              line_full;
    logic              is_short;
    logic              frame_done;
    logic              res_ok_reg;
    logic              res_short_reg;
    logic [bits-1:0]   res_crc_reg;
    logic [len_w-1:0]  res_len_reg;

    assign beat       = in_valid && in_ready_reg;
    assign line_full  = (fill_reg == FILL_FULL);
    assign is_short   = (fill_reg < FILL_FULL);
    assign frame_done = (state_reg == RESULT) && res_ready;

    assign in_ready  = in_ready_reg;
    assign res_ok    = res_ok_reg;
    assign res_short = res_short_reg;
    assign res_crc   = res_crc_reg;
    assign res_len   = res_len_reg;

    // Oldest held byte steps the CRC once the line is full.
    crc_process_byte #(
        .bits (bits),
        .poly (poly)
    ) u_step (
        .refin_in (refin),
        .crc_in   (crc_reg),
        .byte_in  (dl_reg[0]),
        .crc_out  (crc_step)
    );

    // Next-state logic and result-valid decode.
    always_comb begin
        state_next = state_reg;
        res_valid  = 1'b0;
        case (state_reg)
            ACC: begin
                if (beat && in_last) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                state_next = RESULT;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_next = ACC;
                end
            end
            default: begin
                state_next = ACC;
            end
        endcase
    end

    // State register; in_ready is registered from the next state so it is
    // low throughout reset and rises on the first edge after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ACC;
            in_ready_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next == ACC);
        end
    end

    // Delay line: index 0 is the oldest byte, every accepted byte enters at N-1.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dl
            if (gi == N - 1) begin : g_tail
                // Newest byte slot.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        dl_reg[gi] <= '0;
                    end else if (beat) begin
                        dl_reg[gi] <= in_data;
                    end
                end
            end else begin : g_body
                // Shift toward the head.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        dl_reg[gi] <= '0;
                    end else if (beat) begin
                        dl_reg[gi] <= dl_reg[gi+1];
                    end
                end
            end
        end
    endgenerate

    // Received CRC assembled from the held bytes in arrival order.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rx
            if (crc_msb_first) begin : g_msb
                assign rx_crc[bits-1-8*gi -: 8] = dl_reg[gi];
            end else begin : g_lsb
                assign rx_crc[8*gi +: 8] = dl_reg[gi];
            end
        end
    endgenerate

    // Bit-mirror of the CRC register for reflected-output variants.
    generate
        for (genvar gi = 0; gi < bits; gi++) begin : g_refl
            assign crc_refl[gi] = crc_reg[bits-1-gi];
        end
    endgenerate

    assign crc_fin = (refout ? crc_refl : crc_reg) ^ xorout;

    // CRC register, fill count and saturating payload counter.
    always_ff @(posedge clk) begin
        if (rst || frame_done) begin
            crc_reg  <= init;
            fill_reg <= '0;
            len_reg  <= '0;
        end else if (beat) begin
            if (line_full) begin
                crc_reg <= crc_step;
                if (len_reg != '1) begin
                    len_reg <= len_reg + 1'b1;
                end
            end else begin
                fill_reg <= fill_reg + 1'b1;
            end
        end
    end

    // Result registers captured in CALC; they hold after the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            res_ok_reg    <= 1'b0;
            res_short_reg <= 1'b0;
            res_crc_reg   <= '0;
            res_len_reg   <= '0;
        end else if (state_reg == CALC) begin
            // A short frame never stepped the CRC, so crc_fin is finalise(init).
            res_short_reg <= is_short;
            res_ok_reg    <= !is_short && (crc_fin == rx_crc);
            res_crc_reg   <= crc_fin;
            res_len_reg   <= is_short ? '0 : len_reg;
        end
    end

endmodule

// File: tb/tb_crc_frame_checker.sv
// Bench for crc_frame_checker: three instances (CRC-8 with a narrow length
// counter, CRC-16/CCITT-FALSE, CRC-32) driven by directed and random frames,
// checked by a scoreboard against a bit-serial CRC reference model.
module tb_crc_frame_checker;

    typedef struct {
        string       tag;
        logic        ok;
        logic        short_f;
        logic [31:0] crc;
        logic [31:0] len;
    } exp_t;

    int          cfg_bits   [3] = '{8, 16, 32};
    logic [31:0] cfg_poly   [3] = '{32'h07, 32'h1021, 32'h04C11DB7};
    logic [31:0] cfg_init   [3] = '{32'h0, 32'hFFFF, 32'hFFFFFFFF};
    bit          cfg_refin  [3] = '{1'b0, 1'b0, 1'b1};
    bit          cfg_refout [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] cfg_xor    [3] = '{32'h0, 32'h0, 32'hFFFFFFFF};
    bit          cfg_msb    [3] = '{1'b1, 1'b1, 1'b0};
    int          cfg_lmax   [3] = '{15, 65535, 65535};

    logic            clk = 1'b0;
    logic            rst;
    logic [2:0]      in_valid;
    logic [2:0]      in_ready;
    logic [2:0][7:0] in_data;
    logic [2:0]      in_last;
    logic [2:0]      res_valid;
    logic [2:0]      res_ready;
    logic [2:0]      res_ok;
    logic [2:0]      res_short;
    logic [7:0]      res_crc0;
    logic [15:0]     res_crc1;
    logic [31:0]     res_crc2;
    logic [3:0]      res_len0;
    logic [15:0]     res_len1;
    logic [15:0]     res_len2;
    bit   [2:0]      hold_ready;

    int n_cmp = 0;
    int n_mis = 0;

    exp_t sb0[$];
    exp_t sb1[$];
    exp_t sb2[$];

    always #5 clk = ~clk;

    crc_frame_checker #(
        .bits(8), .poly(8'h07), .init(8'h00), .refin(1'b0), .refout(1'b0),
        .xorout(8'h00), .crc_msb_first(1'b1), .len_w(4)
    ) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_last(in_last[0]), .res_valid(res_valid[0]),
        .res_ready(res_ready[0]), .res_ok(res_ok[0]), .res_short(res_short[0]),
        .res_crc(res_crc0), .res_len(res_len0)
    );

    crc_frame_checker #(
        .bits(16), .poly(16'h1021), .init(16'hFFFF), .refin(1'b0), .refout(1'b0),
        .xorout(16'h0000), .crc_msb_first(1'b1), .len_w(16)
    ) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_last(in_last[1]), .res_valid(res_valid[1]),
        .res_ready(res_ready[1]), .res_ok(res_ok[1]), .res_short(res_short[1]),
        .res_crc(res_crc1), .res_len(res_len1)
    );

    crc_frame_checker #(
        .bits(32), .poly(32'h04C11DB7), .init(32'hFFFFFFFF), .refin(1'b1), .refout(1'b1),
        .xorout(32'hFFFFFFFF), .crc_msb_first(1'b0), .len_w(16)
    ) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_last(in_last[2]), .res_valid(res_valid[2]),
        .res_ready(res_ready[2]), .res_ok(res_ok[2]), .res_short(res_short[2]),
        .res_crc(res_crc2), .res_len(res_len2)
    );

    function automatic logic [31:0] get_crc(int k);
        case (k)
            0:       return 32'(res_crc0);
            1:       return 32'(res_crc1);
            default: return res_crc2;
        endcase
    endfunction

    function automatic logic [31:0] get_len(int k);
        case (k)
            0:       return 32'(res_len0);
            1:       return 32'(res_len1);
            default: return 32'(res_len2);
        endcase
    endfunction

    // Reference CRC: one message bit at a time, as in the textbook shift-register definition.
    function automatic logic [31:0] model_crc(int k, logic [7:0] p[$]);
        int          w   = cfg_bits[k];
        logic [31:0] crc = cfg_init[k];
        logic [31:0] r;
        logic        din;
        logic        fb;
        foreach (p[i]) begin
            for (int j = 0; j < 8; j++) begin
                din = cfg_refin[k] ? p[i][j] : p[i][7-j];
                fb  = crc[w-1] ^ din;
                crc = crc << 1;
                if (fb) crc = crc ^ cfg_poly[k];
            end
        end
        if (w < 32) crc = crc & ((32'd1 << w) - 32'd1);
        if (cfg_refout[k]) begin
            r = '0;
            for (int j = 0; j < w; j++) r[w-1-j] = crc[j];
            crc = r;
        end
        return crc ^ cfg_xor[k];
    endfunction

    // Expected result of a whole frame from the frame-level rules.
    function automatic exp_t expect_of(int k, logic [7:0] fr[$]);
        exp_t        e;
        int          n  = cfg_bits[k] / 8;
        int          sz = fr.size();
        logic [7:0]  pl[$];
        logic [31:0] rx = '0;
        e.tag = "random";
        if (sz < n) begin
            e.short_f = 1'b1;
            e.ok      = 1'b0;
            e.len     = 0;
            e.crc     = model_crc(k, pl);
        end else begin
            for (int i = 0; i < sz - n; i++) pl.push_back(fr[i]);
            for (int i = 0; i < n; i++) begin
                if (cfg_msb[k]) rx = (rx << 8) | 32'(fr[sz-n+i]);
                else            rx = rx | (32'(fr[sz-n+i]) << (8 * i));
            end
            e.crc     = model_crc(k, pl);
            e.short_f = 1'b0;
            e.ok      = (rx == e.crc);
            e.len     = (sz - n > cfg_lmax[k]) ? cfg_lmax[k] : sz - n;
        end
        return e;
    endfunction

    task automatic check(string name, int k, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s dut%0d: got %h expected %h", name, k, act, exp);
        end
    endtask

    task automatic push_exp(int k, exp_t e);
        case (k)
            0:       sb0.push_back(e);
            1:       sb1.push_back(e);
            default: sb2.push_back(e);
        endcase
    endtask

    task automatic push_dir(int k, string tag, logic ok, logic sh, logic [31:0] crc, logic [31:0] len);
        exp_t e;
        e.tag = tag; e.ok = ok; e.short_f = sh; e.crc = crc; e.len = len;
        push_exp(k, e);
    endtask

    function automatic int sb_size(int k);
        case (k)
            0:       return sb0.size();
            1:       return sb1.size();
            default: return sb2.size();
        endcase
    endfunction

    task automatic sb_pop(int k, output exp_t e);
        case (k)
            0:       e = sb0.pop_front();
            1:       e = sb1.pop_front();
            default: e = sb2.pop_front();
        endcase
    endtask

    // Monitor: compare each result at its handshake.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (!rst && res_valid[k] && res_ready[k]) begin
                if (sb_size(k) == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL unexpected_result dut%0d: got crc %h expected no result", k, get_crc(k));
                end else begin
                    sb_pop(k, e);
                    $display("dut%0d %s: ok=%0b short=%0b crc=%h len=%0d", k, e.tag,
                             res_ok[k], res_short[k], get_crc(k), get_len(k));
                    check({e.tag, ".res_ok"},    k, 32'(res_ok[k]),    32'(e.ok));
                    check({e.tag, ".res_short"}, k, 32'(res_short[k]), 32'(e.short_f));
                    check({e.tag, ".res_crc"},   k, get_crc(k),        e.crc);
                    check({e.tag, ".res_len"},   k, get_len(k),        e.len);
                end
            end
        end
    end

    // Result back-pressure: random unless held low for a directed test.
    initial begin
        res_ready = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 3; k++)
                res_ready[k] = hold_ready[k] ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Drive one frame; entered and left at posedge+1.
    task automatic send(int k, logic [7:0] fr[$], bit gaps, bit with_last);
        bit acc;
        int cyc;
        for (int i = 0; i < fr.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    @(posedge clk);
                    #1;
                end
            end
            in_valid[k] = 1'b1;
            in_data[k]  = fr[i];
            in_last[k]  = with_last && (i == fr.size() - 1);
            acc = 1'b0;
            cyc = 0;
            while (!acc) begin
                @(negedge clk);
                acc = in_ready[k];
                @(posedge clk);
                #1;
                cyc++;
                if (!acc && cyc > 500) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL in_ready_timeout dut%0d: got in_ready 0 for %0d cycles expected 1", k, cyc);
                    break;
                end
            end
            in_valid[k] = 1'b0;
            in_last[k]  = 1'b0;
        end
    endtask

    task automatic drain();
        int c = 0;
        while ((sb0.size() + sb1.size() + sb2.size()) != 0 && c < 3000) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("scoreboard_drain", 0, 32'(sb0.size() + sb1.size() + sb2.size()), 32'd0);
    endtask

    task automatic digits(output logic [7:0] fr[$]);
        fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    endtask

    task automatic run_random(int k, int nframes);
        int          n = cfg_bits[k] / 8;
        logic [7:0]  pl[$];
        logic [7:0]  fr[$];
        logic [31:0] c;
        int          idx;
        exp_t        e;
        for (int f = 0; f < nframes; f++) begin
            pl.delete();
            fr.delete();
            if (n > 1 && $urandom_range(0, 7) == 0) begin
                for (int i = 0; i < int'($urandom_range(1, n - 1)); i++) fr.push_back(8'($urandom()));
            end else begin
                for (int i = 0; i < int'($urandom_range(0, (k == 0) ? 24 : 12)); i++)
                    pl.push_back(8'($urandom()));
                c  = model_crc(k, pl);
                fr = pl;
                for (int i = 0; i < n; i++) begin
                    if (cfg_msb[k]) fr.push_back(c[8*(n-1-i) +: 8]);
                    else            fr.push_back(c[8*i +: 8]);
                end
                if ($urandom_range(0, 2) == 0) begin
                    idx     = $urandom_range(0, fr.size() - 1);
                    fr[idx] = fr[idx] ^ (8'd1 << $urandom_range(0, 7));
                end
            end
            e = expect_of(k, fr);
            push_exp(k, e);
            send(k, fr, bit'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        logic [7:0] fr[$];

        rst        = 1'b1;
        in_valid   = '0;
        in_last    = '0;
        in_data    = '0;
        hold_ready = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) check("in_ready_during_rst", k, 32'(in_ready[k]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check("in_ready_after_rst",  k, 32'(in_ready[k]),  32'd1);
            check("res_valid_after_rst", k, 32'(res_valid[k]), 32'd0);
            check("res_ok_after_rst",    k, 32'(res_ok[k]),    32'd0);
            check("res_short_after_rst", k, 32'(res_short[k]), 32'd0);
            check("res_crc_after_rst",   k, get_crc(k),        32'd0);
            check("res_len_after_rst",   k, get_len(k),        32'd0);
        end
        @(posedge clk);
        #1;

        // CRC-8 check value, then a corrupted CRC byte, then an exactly-N frame
        digits(fr); fr.push_back(8'hF4);
        push_dir(0, "crc8_good", 1'b1, 1'b0, 32'hF4, 32'd9);
        send(0, fr, 1'b0, 1'b1);
        digits(fr); fr.push_back(8'hF5);
        push_dir(0, "crc8_bad", 1'b0, 1'b0, 32'hF4, 32'd9);
        send(0, fr, 1'b0, 1'b1);
        fr = '{8'h00};
        push_dir(0, "crc8_empty", 1'b1, 1'b0, 32'h00, 32'd0);
        send(0, fr, 1'b0, 1'b1);

        // CRC-16 with result held back: latency, stability and input stall
        hold_ready[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        digits(fr); fr.push_back(8'h29); fr.push_back(8'hB1);
        push_dir(1, "crc16_hold", 1'b1, 1'b0, 32'h29B1, 32'd9);
        send(1, fr, 1'b0, 1'b1);
        @(negedge clk);
        check("res_valid_in_calc", 1, 32'(res_valid[1]), 32'd0);
        check("in_ready_in_calc",  1, 32'(in_ready[1]),  32'd0);
        @(negedge clk);
        check("res_valid_latency", 1, 32'(res_valid[1]), 32'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("hold_res_valid", 1, 32'(res_valid[1]), 32'd1);
            check("hold_in_ready",  1, 32'(in_ready[1]),  32'd0);
            check("hold_res_crc",   1, get_crc(1),        32'h29B1);
            check("hold_res_ok",    1, 32'(res_ok[1]),    32'd1);
        end
        @(posedge clk);
        #1;
        hold_ready[1] = 1'b0;

        // Same CRC-16 frame with random input gaps
        digits(fr); fr.push_back(8'h29); fr.push_back(8'hB1);
        push_dir(1, "crc16_gaps", 1'b1, 1'b0, 32'h29B1, 32'd9);
        send(1, fr, 1'b1, 1'b1);
        fr = '{8'h00};
        push_dir(1, "crc16_short", 1'b0, 1'b1, 32'hFFFF, 32'd0);
        send(1, fr, 1'b0, 1'b1);
        fr = '{8'hFF, 8'hFF};
        push_dir(1, "crc16_empty", 1'b1, 1'b0, 32'hFFFF, 32'd0);
        send(1, fr, 1'b0, 1'b1);

        // CRC-32, reflected, CRC bytes least-significant first; then a short frame
        digits(fr); fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4); fr.push_back(8'hCB);
        push_dir(2, "crc32_good", 1'b1, 1'b0, 32'hCBF43926, 32'd9);
        send(2, fr, 1'b0, 1'b1);
        fr = '{8'h00};
        push_dir(2, "crc32_short", 1'b0, 1'b1, 32'h00000000, 32'd0);
        send(2, fr, 1'b0, 1'b1);

        drain();

        // Reset in the middle of a frame, then a clean frame
        fr = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
        send(0, fr, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_mid_rst", 0, 32'(in_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("in_ready_after_mid_rst", 0, 32'(in_ready[0]),  32'd1);
        check("res_valid_after_mid_rst", 0, 32'(res_valid[0]), 32'd0);
        check("res_len_after_mid_rst",  0, get_len(0),        32'd0);
        @(posedge clk);
        #1;
        digits(fr); fr.push_back(8'hF4);
        push_dir(0, "crc8_after_rst", 1'b1, 1'b0, 32'hF4, 32'd9);
        send(0, fr, 1'b0, 1'b1);

        // Random frames on all three instances at once (CRC-8 covers length saturation)
        fork
            run_random(0, 20);
            run_random(1, 15);
            run_random(2, 15);
        join

        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
